stream_sink: RTL and testbench

- Parametrised terminal sink for valid/ready streams. It succeeds the fixed 8-bit byte sink.
- Buffers incoming words in a DEPTH-entry FIFO and drains them at a programmable rate, so upstream sees real backpressure.
- Keeps a running word count, a wraparound checksum and the last drained word as observable status.
- Used as the end-of-chain load for UART RX and other stream producers, in both bench and silicon debug builds.

---
 rtl/stream_sink.sv | 122 ++++++++++++
 tb/tb_stream_sink.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sink.sv
// stream_sink: terminal valid/ready sink with a DEPTH-entry FIFO, rate-limited drain and
// status (last word, count, checksum, level). Define STREAM_SINK_OVERFLOW_EN for sticky _overflow.
module stream_sink #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int STALL   = 0,
    parameter int COUNT_W = 16
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic [WIDTH-1:0]        _in,
    input  logic                    _in_valid,
    output logic                    _in_ready,
    input  logic                    _drain_en,
    output logic [WIDTH-1:0]        _data,
    output logic [COUNT_W-1:0]      _count,
    output logic [WIDTH-1:0]        _checksum,
    output logic [$clog2(DEPTH):0]  _level
`ifdef STREAM_SINK_OVERFLOW_EN
    ,
    output logic                    _overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = (STALL > 0) ? $clog2(STALL + 1) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STALL);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TMR_W-1:0]   wait_q, wait_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               push;
    logic               pop;

    // The drain timer counts down the idle cycles still owed before the next pop.
    always_comb begin
        _in_ready = _reset && (level_q != FULL_LVL);
        push      = _in_valid && _in_ready;
        pop       = _drain_en && (level_q != '0) && (wait_q == '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wait_d    = wait_q;
        data_d    = data_q;
        count_d   = count_q;
        sum_d     = sum_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            data_d   = mem_q[rd_ptr_q];
            count_d  = count_q + COUNT_W'(1);
            sum_d    = sum_q + mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wait_d   = TMR_RELOAD;
        end else if (_drain_en && (wait_q != '0)) begin
            wait_d = wait_q - TMR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= _in;
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wait_q   <= '0;
            data_q   <= '0;
            count_q  <= '0;
            sum_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
        end
    end

    assign _data     = data_q;
    assign _count    = count_q;
    assign _checksum = sum_q;
    assign _level    = level_q;

`ifdef STREAM_SINK_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (_in_valid && _reset && !_in_ready);
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign _overflow = ovf_q;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// Bench for stream_sink: table-driven vectors plus scoreboard of accepted words,
// with hand-written sequences for wrap, reset and STALL timing.
module tb_stream_sink;

    logic       clk;
    logic       rst_n;
    logic [7:0] in0, in2;
    logic       v0, v2, drain0, drain2;
    logic       ready0, ready2;
    logic [7:0] data0, data2, sum0, sum2;
    logic [3:0] cnt0;
    logic [15:0] cnt2;
    logic [2:0] lvl0, lvl2;
`ifdef STREAM_SINK_OVERFLOW_EN
    logic       ovf0, ovf2;
`endif

    stream_sink #(.WIDTH(8), .DEPTH(4), .STALL(0), .COUNT_W(4)) dut0 (
        ._clock(clk), ._reset(rst_n), ._in(in0), ._in_valid(v0), ._in_ready(ready0),
        ._drain_en(drain0), ._data(data0), ._count(cnt0), ._checksum(sum0), ._level(lvl0)
`ifdef STREAM_SINK_OVERFLOW_EN
        , ._overflow(ovf0)
`endif
    );

    stream_sink #(.WIDTH(8), .DEPTH(4), .STALL(2), .COUNT_W(16)) dut2 (
        ._clock(clk), ._reset(rst_n), ._in(in2), ._in_valid(v2), ._in_ready(ready2),
        ._drain_en(drain2), ._data(data2), ._count(cnt2), ._checksum(sum2), ._level(lvl2)
`ifdef STREAM_SINK_OVERFLOW_EN
        , ._overflow(ovf2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for dut0: words queued on accept, checked when _count moves.
    logic [7:0] exp_q[$];
    logic [3:0] prev_cnt = 4'd0;
    logic [3:0] m_cnt = 4'd0;
    logic [7:0] m_sum = 8'd0;

    always @(negedge clk) begin
        if (rst_n && (cnt0 != prev_cnt)) begin
            logic [7:0] w;
            prev_cnt = cnt0;
            m_cnt    = m_cnt + 4'd1;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(cnt0), 32'(prev_cnt - 4'd1));
            end else begin
                w = exp_q.pop_front();
                chk("sb_data", 32'(data0), 32'(w));
                m_sum = m_sum + w;
            end
            chk("sb_count", 32'(cnt0), 32'(m_cnt));
            chk("sb_sum", 32'(sum0), 32'(m_sum));
        end
    end

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic       drn;
        logic       exp_rdy;
        logic [2:0] exp_lvl;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic vl, input logic dr,
                                input logic rdy, input logic [2:0] lv, input logic [3:0] c);
        vec_t v;
        v.din = d; v.vld = vl; v.drn = dr; v.exp_rdy = rdy; v.exp_lvl = lv; v.exp_cnt = c;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v2 = 1'b0; in0 = '0; in2 = '0;
        exp_q.delete();
        prev_cnt = '0; m_cnt = '0; m_sum = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [7:0] d, input logic vl, input logic dr);
        in0 = d; v0 = vl; drain0 = dr;
        @(negedge clk);
        if (vl && ready0) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    int el2 [12] = '{1, 1, 2, 3, 2, 2, 2, 1, 1, 1, 0, 0};
    int ec2 [12] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4};

    initial begin
        rst_n = 1'b0;
        in0 = '0; in2 = '0; v0 = 1'b0; v2 = 1'b0; drain0 = 1'b1; drain2 = 1'b1;
        #2;
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_sum", 32'(sum0), 32'd0);
        chk("rst_level", 32'(lvl0), 32'd0);
`ifdef STREAM_SINK_OVERFLOW_EN
        chk("rst_ovf", 32'(ovf0), 32'd0);
`endif
        do_reset();

        // Three back-to-back pushes, draining every cycle.
        vecs.push_back(mk(8'h11, 1, 1, 1, 0, 0));
        vecs.push_back(mk(8'h22, 1, 1, 1, 1, 0));
        vecs.push_back(mk(8'h33, 1, 1, 1, 1, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 1, 2));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0, 3));
        // Drain paused: fill, stall the 5th word, then release the drain.
        vecs.push_back(mk(8'hA1, 1, 0, 1, 0, 3));
        vecs.push_back(mk(8'hA2, 1, 0, 1, 1, 3));
        vecs.push_back(mk(8'hA3, 1, 0, 1, 2, 3));
        vecs.push_back(mk(8'hA4, 1, 0, 1, 3, 3));
        vecs.push_back(mk(8'hA5, 1, 0, 0, 4, 3));
        vecs.push_back(mk(8'hA5, 1, 0, 0, 4, 3));
        vecs.push_back(mk(8'hA5, 1, 1, 0, 4, 3));
        vecs.push_back(mk(8'hA5, 1, 1, 1, 3, 4));
        vecs.push_back(mk(8'hA6, 1, 1, 1, 3, 5));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3, 6));
        vecs.push_back(mk(8'h00, 0, 1, 1, 2, 7));
        vecs.push_back(mk(8'h00, 0, 1, 1, 1, 8));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0, 9));
        // Full with a same-edge pop: level 4, 3, 4.
        vecs.push_back(mk(8'hB1, 1, 0, 1, 0, 9));
        vecs.push_back(mk(8'hB2, 1, 0, 1, 1, 9));
        vecs.push_back(mk(8'hB3, 1, 0, 1, 2, 9));
        vecs.push_back(mk(8'hB4, 1, 0, 1, 3, 9));
        vecs.push_back(mk(8'hB5, 1, 1, 0, 4, 9));
        vecs.push_back(mk(8'hB5, 1, 0, 1, 3, 10));
        vecs.push_back(mk(8'h00, 0, 1, 0, 4, 10));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3, 11));
        vecs.push_back(mk(8'h00, 0, 1, 1, 2, 12));
        vecs.push_back(mk(8'h00, 0, 1, 1, 1, 13));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0, 14));

        foreach (vecs[i]) begin
            in0 = vecs[i].din; v0 = vecs[i].vld; drain0 = vecs[i].drn;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(ready0), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_level", i), 32'(lvl0), 32'(vecs[i].exp_lvl));
            chk($sformatf("v%0d_count", i), 32'(cnt0), 32'(vecs[i].exp_cnt));
            if (vecs[i].vld && ready0) exp_q.push_back(vecs[i].din);
            @(posedge clk);
            #1;
        end
        chk("table_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef STREAM_SINK_OVERFLOW_EN
        chk("ovf_sticky", 32'(ovf0), 32'd1);
`endif

        // Checksum wrap.
        do_reset();
`ifdef STREAM_SINK_OVERFLOW_EN
        chk("ovf_cleared", 32'(ovf0), 32'd0);
`endif
        cyc(8'hF0, 1, 1);
        cyc(8'h20, 1, 1);
        for (int i = 0; i < 3; i++) cyc(8'h00, 0, 1);
        chk("csum_wrap", 32'(sum0), 32'h10);
        chk("csum_count", 32'(cnt0), 32'd2);

        // Counter wrap at COUNT_W=4.
        do_reset();
        for (int i = 0; i < 17; i++) cyc(8'(i + 1), 1, 1);
        for (int i = 0; i < 3; i++) cyc(8'h00, 0, 1);
        chk("cnt_wrap", 32'(cnt0), 32'd1);
        chk("cnt_wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-drain with level 3.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(8'hC1 + 8'(i), 1, 0);
        cyc(8'h00, 0, 1);
        chk("mid_pre_level", 32'(lvl0), 32'd3);
        chk("mid_pre_count", 32'(cnt0), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        prev_cnt = '0; m_cnt = '0; m_sum = '0;
        #1;
        chk("mid_rst_data", 32'(data0), 32'd0);
        chk("mid_rst_count", 32'(cnt0), 32'd0);
        chk("mid_rst_sum", 32'(sum0), 32'd0);
        chk("mid_rst_level", 32'(lvl0), 32'd0);
        chk("mid_rst_ready", 32'(ready0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(8'hAA, 1, 1);
        for (int i = 0; i < 4; i++) cyc(8'h00, 0, 1);
        chk("post_rst_data", 32'(data0), 32'hAA);
        chk("post_rst_count", 32'(cnt0), 32'd1);
        chk("post_rst_level", 32'(lvl0), 32'd0);
        chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        // STALL=2 instance: pops on edges 2, 5, 8, 11.
        do_reset();
        drain2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in2 = 8'(k);
            v2  = (k <= 4);
            @(negedge clk);
            chk($sformatf("s2_e%0d_ready", k), 32'(ready2), 32'd1);
            @(posedge clk);
            #1;
            v2 = 1'b0;
            chk($sformatf("s2_e%0d_count", k), 32'(cnt2), 32'(ec2[k-1]));
            chk($sformatf("s2_e%0d_level", k), 32'(lvl2), 32'(el2[k-1]));
        end
        chk("s2_data", 32'(data2), 32'h04);
        // Timer saturated while empty: next word drains one edge after arrival.
        in2 = 8'h05; v2 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        chk("s2_sat_push_count", 32'(cnt2), 32'd4);
        chk("s2_sat_push_level", 32'(lvl2), 32'd1);
        @(posedge clk);
        #1;
        chk("s2_sat_pop_count", 32'(cnt2), 32'd5);
        chk("s2_sat_pop_data", 32'(data2), 32'h05);
        chk("s2_sum", 32'(sum2), 32'h0F);
`ifdef STREAM_SINK_OVERFLOW_EN
        chk("s2_ovf", 32'(ovf2), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
